// File: rtl/sargantana_icache_pkg.sv
// Shared types for the sargantana instruction cache.
// Request payload layout and default request-pipe depth.
package sargantana_icache_pkg;

  localparam int ICACHE_PIPE_DEPTH = 2;

  localparam int ICACHE_IDX_W = 6;
  localparam int ICACHE_VPN_W = 27;
  localparam int ICACHE_TAG_W = 20;
  localparam int ICACHE_WAY_W = 2;
  localparam int ICACHE_PPN_W = 20;

  typedef struct packed {
    logic                    miss;
    logic                    ptw_v;
    logic                    xcpt;
    logic [ICACHE_PPN_W-1:0] ppn;
  } mmu_tresp_t;

  typedef struct packed {
    logic [ICACHE_IDX_W-1:0] idx;
    logic [ICACHE_VPN_W-1:0] vpn;
    logic [ICACHE_TAG_W-1:0] cline_tag;
    logic [ICACHE_WAY_W-1:0] way_to_replace;
    logic                    cmp_enable;
    logic                    valid_ireq;
    mmu_tresp_t              tresp;
  } icache_req_payload_t;

endpackage

// File: rtl/sargantana_icache_pipe_slot.sv
// One valid/data register of the icache request pipe.
// Ready is combinational: free slot or the next slot moves on.
module sargantana_icache_pipe_slot
  import sargantana_icache_pkg::*;
#(
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 kill,
  input  logic                 src_valid,
  input  logic [PAYLOAD_W-1:0] src_data,
  input  logic                 nxt_ready,
  output logic                 ready,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] data
);

  assign ready = !valid || nxt_ready;

  // Kill only drops validity; the payload register keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= src_valid;
      if (src_valid) data <= src_data;
    end
  end

endmodule

// File: rtl/sargantana_icache_pipe_stage.sv
// Elastic DEPTH-stage request pipe with kill and occupancy.
// Optional stall counter: SARGANTANA_ICACHE_PIPE_PERF_EN.
module sargantana_icache_pipe_stage
  import sargantana_icache_pkg::*;
#(
  parameter  int PAYLOAD_W = 64,
  parameter  int DEPTH     = ICACHE_PIPE_DEPTH,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o,
  input  logic                 kill_i,
  output logic [OCC_W-1:0]     occ_o
`ifdef SARGANTANA_ICACHE_PIPE_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt_o
`endif
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("DEPTH must be at least 1");
  end
  if (PAYLOAD_W < 1) begin : g_width_chk
    $error("PAYLOAD_W must be at least 1");
  end

  // Index k+1 carries the outputs of slot k; index 0 is the input port.
  logic [DEPTH:0]       sv;
  logic [PAYLOAD_W-1:0] sd [DEPTH+1];
  logic [DEPTH:0]       rdy;

  assign sv[0]      = in_valid_i;
  assign sd[0]      = in_data_i;
  assign rdy[DEPTH] = out_ready_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    sargantana_icache_pipe_slot #(
      .PAYLOAD_W(PAYLOAD_W)
    ) u_slot (
      .clk      (clk_i),
      .rst      (rst_i),
      .kill     (kill_i),
      .src_valid(sv[k]),
      .src_data (sd[k]),
      .nxt_ready(rdy[k+1]),
      .ready    (rdy[k]),
      .valid    (sv[k+1]),
      .data     (sd[k+1])
    );
  end

  assign in_ready_o  = rdy[0];
  assign out_valid_o = sv[DEPTH] && !kill_i;
  assign out_data_o  = sd[DEPTH];

  always_comb begin
    occ_o = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      occ_o = occ_o + OCC_W'(sv[k]);
    end
  end

`ifdef SARGANTANA_ICACHE_PIPE_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cnt <= '0;
    end else if (sv[DEPTH] && !out_ready_i && !kill_i
                 && perf_cnt != 32'hFFFF_FFFF) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_cnt;
`endif

endmodule

// File: tb/tb_sargantana_icache_pipe_stage.sv
// Bench for sargantana_icache_pipe_stage (DEPTH=3, PAYLOAD_W=8):
// directed vector table, queue-model random run, optional perf check.
module tb_sargantana_icache_pipe_stage;

  localparam int D = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, kill;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occ;
`ifdef SARGANTANA_ICACHE_PIPE_PERF_EN
  logic [31:0]  perf_cnt;
`endif

  always #5 clk = ~clk;

  sargantana_icache_pipe_stage #(
    .PAYLOAD_W(W),
    .DEPTH    (D)
  ) dut (
`ifdef SARGANTANA_ICACHE_PIPE_PERF_EN
    .perf_stall_cnt_o(perf_cnt),
`endif
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .kill_i     (kill),
    .occ_o      (occ)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: ordered list of live requests (oldest first) with their stage.
  typedef struct {
    int           p;
    logic [W-1:0] v;
  } ent_t;

  ent_t         q[$];
  logic [W-1:0] m_last = '0;

  function automatic bit model_ready(input bit orr);
    int lim = D - 1;
    int np;
    foreach (q[i]) begin
      if (i == 0 && q[i].p == D - 1 && orr) continue;
      np  = (q[i].p + 1 < lim) ? q[i].p + 1 : lim;
      lim = np - 1;
    end
    return lim >= 0;
  endfunction

  function automatic void model_step(input bit r, input bit iv,
                                     input logic [W-1:0] din,
                                     input bit orr, input bit k);
    ent_t nq[$];
    int   lim = D - 1;
    int   np;
    bit   rdy0;
    if (r) begin
      q.delete();
      m_last = '0;
      return;
    end
    if (k) begin
      q.delete();
      return;
    end
    rdy0 = model_ready(orr);
    foreach (q[i]) begin
      if (i == 0 && q[i].p == D - 1 && orr) continue;
      np = (q[i].p + 1 < lim) ? q[i].p + 1 : lim;
      if (np == D - 1 && q[i].p != D - 1) m_last = q[i].v;
      nq.push_back('{np, q[i].v});
      lim = np - 1;
    end
    if (iv && rdy0) nq.push_back('{0, din});
    q = nq;
  endfunction

  task automatic apply(input bit r, input bit iv, input logic [W-1:0] din,
                       input bit orr, input bit k);
    rst       = r;
    in_valid  = iv;
    in_data   = din;
    out_ready = orr;
    kill      = k;
  endtask

  task automatic model_cycle(input bit r, input bit iv,
                             input logic [W-1:0] din,
                             input bit orr, input bit k);
    apply(r, iv, din, orr, k);
    @(negedge clk);
    chk("rnd_out_valid", 32'(out_valid),
        32'(q.size() > 0 && q[0].p == D - 1 && !k));
    chk("rnd_out_data", 32'(out_data), 32'(m_last));
    chk("rnd_in_ready", 32'(in_ready), 32'(model_ready(orr)));
    chk("rnd_occ", 32'(occ), 32'(q.size()));
    model_step(r, iv, din, orr, k);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit           r, iv;
    logic [W-1:0] din;
    bit           orr, k;
    bit           ov;
    logic [W-1:0] od;
    bit           ir;
    int           occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit iv, logic [W-1:0] din, bit orr,
                              bit k, bit ov, logic [W-1:0] od, bit ir,
                              int oc);
    vec_t t;
    t = '{r, iv, din, orr, k, ov, od, ir, oc};
    return t;
  endfunction

  initial begin
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // stream
    tbl.push_back(mk(0, 1, 8'h01, 1, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 8'h02, 1, 0, 0, 8'h00, 1, 1));
    tbl.push_back(mk(0, 1, 8'h03, 1, 0, 0, 8'h00, 1, 2));
    tbl.push_back(mk(0, 1, 8'h04, 1, 0, 1, 8'h01, 1, 3));
    tbl.push_back(mk(0, 1, 8'h05, 1, 0, 1, 8'h02, 1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h03, 1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h04, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h05, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h05, 1, 0));
    // backpressure
    tbl.push_back(mk(0, 1, 8'h10, 0, 0, 0, 8'h05, 1, 0));
    tbl.push_back(mk(0, 1, 8'h11, 0, 0, 0, 8'h05, 1, 1));
    tbl.push_back(mk(0, 1, 8'h12, 0, 0, 0, 8'h05, 1, 2));
    tbl.push_back(mk(0, 1, 8'h13, 0, 0, 1, 8'h10, 0, 3));
    tbl.push_back(mk(0, 1, 8'h13, 1, 0, 1, 8'h10, 1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h11, 0, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h11, 1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h12, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h13, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h13, 1, 0));
    // bubble collapse
    tbl.push_back(mk(0, 1, 8'hA0, 0, 0, 0, 8'h13, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h13, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h13, 1, 1));
    tbl.push_back(mk(0, 1, 8'hA1, 0, 0, 1, 8'hA0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'hA0, 1, 2));
    // kill with a full pipe and a concurrent input
    tbl.push_back(mk(0, 1, 8'hA2, 0, 0, 1, 8'hA0, 1, 2));
    tbl.push_back(mk(0, 1, 8'h55, 1, 1, 0, 8'hA0, 1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'hA0, 1, 0));
    // reset mid-stream
    tbl.push_back(mk(0, 1, 8'h21, 0, 0, 0, 8'hA0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h22, 0, 0, 0, 8'hA0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'hA0, 1, 2));
    // reset together with kill
    tbl.push_back(mk(0, 1, 8'h31, 1, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 1, 8'h32, 1, 1, 0, 8'h00, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].iv, tbl[i].din, tbl[i].orr, tbl[i].k);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("v%0d_occ", i), 32'(occ), 32'(tbl[i].occ));
      @(posedge clk);
      #1;
    end

    // random traffic against the queue model
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    model_step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 600; n++) begin
      model_cycle(($urandom_range(99) < 2),
                  ($urandom_range(99) < 70),
                  W'($urandom),
                  ($urandom_range(99) < 55),
                  ($urandom_range(99) < 3));
    end

`ifdef SARGANTANA_ICACHE_PIPE_PERF_EN
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("perf_reset", perf_cnt, 32'd0);
    @(posedge clk);
    #1;
    apply(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2 + 7) @(posedge clk);
    #1;
    apply(1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("perf_stall_7", perf_cnt, 32'd7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_pipe_stage.md
Name: sargantana_icache_pipe_stage

Overview:
- Parametrised elastic pipeline register for the instruction-cache request path.
- Replaces fixed per-signal flop banks with DEPTH valid/ready stages carrying an opaque PAYLOAD_W payload (idx, vpn, tag, way, flags, packed by the caller).
- Adds backpressure, bubble collapsing, kill of in-flight requests and an occupancy report.
- Sits between the fetch-request front end and the tag-compare/fill logic of sargantana_icache.

Parameters:
- PAYLOAD_W, 64, payload width in bits, must be at least 1.
- DEPTH, 2, number of register stages, must be at least 1; DEPTH=0 is an elaboration error.
- OCC_W, $clog2(DEPTH+1), width of the occupancy output (derived, not overridable).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  upstream request valid
- in_ready_o  out  1  stage 0 can accept this cycle
- in_data_i  in  PAYLOAD_W  upstream payload
- out_valid_o  out  1  last stage holds a live request
- out_ready_i  in  1  downstream accepts
- out_data_o  out  PAYLOAD_W  payload of the last stage
- kill_i  in  1  drop all in-flight requests (ireq kill or flush)
- occ_o  out  OCC_W  number of valid stages
- perf_stall_cnt_o  out  32  stall counter, present only with the optional feature

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Stages are numbered k=0 (input side) to DEPTH-1 (output side). Each stage holds v[k] and d[k].
- Readiness:
  - rdy[DEPTH] = out_ready_i.
  - rdy[k] = !v[k] || rdy[k+1]. This is a combinational ready chain with no skid.
  - in_ready_o = rdy[0].
- Per cycle, for each k, if rdy[k]:
  - v[k] <= source valid (in_valid_i for k=0, else v[k-1]).
  - d[k] <= source data, loaded only when the source valid is 1. Otherwise d[k] holds.
- If !rdy[k], the stage holds both v[k] and d[k].
- Outputs:
  - out_valid_o = v[DEPTH-1] && !kill_i.
  - out_data_o = d[DEPTH-1].
- Transfer rules:
  - Input transfer: in_valid_i && in_ready_o.
  - Output transfer: out_valid_o && out_ready_i.
  - Once accepted, in_data_i must not be re-presented by upstream. Payload values are never reordered or duplicated.
- Timing:
  - Latency with no backpressure is DEPTH cycles from input transfer to out_valid_o.
  - Throughput is 1 request per cycle.
  - Bubbles collapse: a stall at the output fills the empty upstream stages before in_ready_o deasserts.
- Full: all v=1 and out_ready_i=0 gives in_ready_o=0 and occ_o=DEPTH.
- Empty: occ_o=0 and out_valid_o=0. in_data_i still needs DEPTH cycles to reach the output; there is no bypass.
- Simultaneous in and out transfer when full: allowed. Occupancy is unchanged.
- kill_i:
  - Next cycle, all v=0.
  - Any input transfer in the kill cycle is dropped, and in_ready_o is not masked.
  - out_valid_o is forced to 0 in the kill cycle, so no output transfer occurs.
  - d registers are untouched.
- kill_i together with rst_i: reset wins, with identical effect on v.
- Reset (synchronous, rst_i=1 at a clk_i edge): all v=0 and all d=0, hence out_valid_o=0, out_data_o=0 and occ_o=0.
  - in_ready_o=1 while v=0, because it is combinational.
  - Reset mid-stream discards all entries without an output transfer.
- occ_o: popcount of v, registered-equivalent, reflecting current stage state (not the next state).

Optional Feature:
- Macro: SARGANTANA_ICACHE_PIPE_PERF_EN.
- Defined:
  - perf_stall_cnt_o is present.
  - It increments by 1 each cycle with v[DEPTH-1]=1 && out_ready_i=0 && kill_i=0.
  - It saturates at 32'hFFFF_FFFF and is cleared to 0 by rst_i.
- Undefined: the port and the counter are absent, and there is no extra logic.

Decomposition:
- In sargantana_icache_pkg:
  - typedef icache_req_payload_t, the packed struct of idx, vpn, cline_tag, way_to_replace, cmp_enable, valid_ireq and mmu tresp.
  - constant ICACHE_PIPE_DEPTH.
  - Callers set PAYLOAD_W = $bits(icache_req_payload_t).
- One sub-module: sargantana_icache_pipe_slot, holding a single v/d register with the rdy equation. The top instantiates DEPTH of them in a generate loop, with the popcount and the perf counter at the top.

Test Plan (DEPTH=3, PAYLOAD_W=8):
- Stream: in_valid=1, values 0x01..0x05 on consecutive cycles, out_ready=1 → out_valid rises at cycle 3; outputs 0x01..0x05 back-to-back; occ_o reaches 3.
- Backpressure: fill with 0x10, 0x11, 0x12 while out_ready=0 → in_ready=0 and occ_o=3; release out_ready for 1 cycle → 0x10 is delivered, in_ready=1 in the same cycle, and 0x13 is accepted.
- Bubble collapse: issue 0xA0, idle 2 cycles, issue 0xA1, out_ready=0 → both entries occupy stages 2 and 1; occ_o=2; in_ready stays 1.
- Kill: full pipe, with kill_i=1 and in_valid=1 (0x55) in the same cycle → out_valid=0 that cycle; next cycle occ_o=0; 0x55 never appears.
- Reset mid-stream: rst_i=1 for 1 cycle with occ_o=2 → next cycle occ_o=0, out_data_o=0x00, in_ready=1.
- PERF_EN: 7 stall cycles, then 1 kill cycle with a stall → perf_stall_cnt_o=7. With the counter preloaded near its maximum, it holds at 32'hFFFF_FFFF.
